// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit.
// Loads and stores go to a multi-cycle req/ack memory. The upstream pipeline
// is frozen while an access is outstanding. Non-memory instructions pass
// straight through to the write-back result registers in a single cycle.
//
// Memory handshake: mem_req rises with mem_addr/mem_we/mem_wdata already
// stable and stays high until the cycle in which mem_ack pulses (or the
// timeout expires). mem_ack is only honoured while waiting. mem_rdata is
// sampled in the same cycle that mem_ack is high.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        WB_EN_IN,
   input  logic        MEM_R_EN_IN,
   input  logic        MEM_W_EN_IN,
   input  logic [31:0] ALUResIn,
   input  logic [31:0] STValIn,
   input  logic [4:0]  destIn,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        freeze,
   output logic        WB_EN,
   output logic        MEM_R_EN,
   output logic [31:0] ALURes,
   output logic [31:0] memData,
   output logic [4:0]  dest,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Last counter value before the access is abandoned; gives exactly
   // TIMEOUT cycles in the waiting state.
   localparam logic [15:0] C_LAST = 16'(TIMEOUT - 1);

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [31:0] r_load;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic        r_wb_en;
   logic        r_mem_r_en;
   logic [31:0] r_alu_res;
   logic [31:0] r_mem_data;
   logic [4:0]  r_dest;
   logic        r_err;

   logic        w_mem_op;

   assign w_mem_op = MEM_R_EN_IN | MEM_W_EN_IN;

   // Stall while waiting and in the cycle a memory op is first seen; the
   // result-load cycle (DONE) lets the pipeline advance.
   assign freeze = (r_state == S_WAIT) | ((r_state == S_IDLE) & w_mem_op);

   // Access FSM together with all registered memory-side and result outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_load      <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_wb_en     <= 1'b0;
         r_mem_r_en  <= 1'b0;
         r_alu_res   <= '0;
         r_mem_data  <= '0;
         r_dest      <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_mem_op) begin
                  // Read wins when both enables are set.
                  r_mem_addr  <= {ALUResIn[31:2], 2'b00};
                  r_mem_wdata <= STValIn;
                  r_mem_we    <= MEM_W_EN_IN & ~MEM_R_EN_IN;
                  r_mem_req   <= 1'b1;
                  r_cnt       <= '0;
                  r_wb_en     <= 1'b0;
                  r_state     <= S_WAIT;
               end else begin
                  r_wb_en    <= WB_EN_IN;
                  r_mem_r_en <= 1'b0;
                  r_alu_res  <= ALUResIn;
                  r_dest     <= destIn;
                  r_mem_data <= '0;
               end
            end
            S_WAIT: begin
               if (mem_ack) begin
                  // Stores return nothing useful; keep the load register clean.
                  r_load    <= r_mem_we ? 32'h0 : mem_rdata;
                  r_mem_req <= 1'b0;
                  r_state   <= S_DONE;
               end else if (r_cnt == C_LAST) begin
                  r_load    <= '0;
                  r_mem_req <= 1'b0;
                  r_err     <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_DONE: begin
               r_wb_en    <= WB_EN_IN;
               r_mem_r_en <= MEM_R_EN_IN;
               r_alu_res  <= ALUResIn;
               r_dest     <= destIn;
               r_mem_data <= r_load;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign WB_EN     = r_wb_en;
   assign MEM_R_EN  = r_mem_r_en;
   assign ALURes    = r_alu_res;
   assign memData   = r_mem_data;
   assign dest      = r_dest;
   assign err       = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: pass-through vector table plus hand-written
// multi-cycle memory sequences (load, store, back-to-back, timeout, reset).
module tb_mem_access_unit;

   localparam int unsigned TMO = 4;

   logic        clk;
   logic        rst;
   logic        WB_EN_IN;
   logic        MEM_R_EN_IN;
   logic        MEM_W_EN_IN;
   logic [31:0] ALUResIn;
   logic [31:0] STValIn;
   logic [4:0]  destIn;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        freeze;
   logic        WB_EN;
   logic        MEM_R_EN;
   logic [31:0] ALURes;
   logic [31:0] memData;
   logic [4:0]  dest;
   logic        err;

   int n_checks = 0;
   int n_err    = 0;
   int req_rises = 0;
   logic req_prev = 1'b0;
   logic [31:0] exp_q[$];

   mem_access_unit #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
      .ALUResIn(ALUResIn), .STValIn(STValIn), .destIn(destIn),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .freeze(freeze), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
      .ALURes(ALURes), .memData(memData), .dest(dest), .err(err)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges of mem_req (one per request sequence)
   always @(negedge clk) begin
      if (mem_req && !req_prev) req_rises++;
      req_prev = mem_req;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      WB_EN_IN    = 1'b0;
      MEM_R_EN_IN = 1'b0;
      MEM_W_EN_IN = 1'b0;
      ALUResIn    = 32'h0;
      STValIn     = 32'h0;
      destIn      = 5'd0;
   endtask

   // One memory instruction held on the inputs until the unit releases it.
   // k = cycle (after presentation) in which ack is pulsed; k = 0 means never.
   task automatic do_mem(input string tag, input logic rd, input logic wr, input logic wb,
                         input logic [31:0] addr, input logic [31:0] sv, input logic [4:0] dst,
                         input int k, input logic [31:0] rdata, input logic exp_err);
      int cyc;
      int exp_frz;
      exp_q.push_back((rd && k > 0) ? rdata : 32'h0);
      exp_frz = (k > 0) ? k + 1 : int'(TMO) + 1;
      WB_EN_IN    = wb;
      MEM_R_EN_IN = rd;
      MEM_W_EN_IN = wr;
      ALUResIn    = addr;
      STValIn     = sv;
      destIn      = dst;
      #1;
      cyc = 0;
      while (freeze === 1'b1 && cyc < 50) begin
         if (cyc == 1) begin
            check({tag, " mem_req"},   32'(mem_req), 32'h1);
            check({tag, " mem_addr"},  mem_addr, {addr[31:2], 2'b00});
            check({tag, " mem_we"},    32'(mem_we), 32'(wr & ~rd));
            check({tag, " mem_wdata"}, mem_wdata, sv);
            check({tag, " bubble WB_EN"}, 32'(WB_EN), 32'h0);
         end
         if (k > 0 && cyc == k) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
         end
         step();
         mem_ack   = 1'b0;
         mem_rdata = 32'hBAD0_0000 | 32'(cyc);
         cyc++;
      end
      check({tag, " freeze cycles"}, 32'(cyc), 32'(exp_frz));
      check({tag, " mem_req dropped"}, 32'(mem_req), 32'h0);
      check({tag, " err"}, 32'(err), 32'(exp_err));
      step();
      check({tag, " WB_EN"},    32'(WB_EN), 32'(wb));
      check({tag, " MEM_R_EN"}, 32'(MEM_R_EN), 32'(rd));
      check({tag, " ALURes"},   ALURes, addr);
      check({tag, " dest"},     32'(dest), 32'(dst));
      check({tag, " memData"},  memData, exp_q.pop_front());
   endtask

   typedef struct {
      logic        wb;
      logic [31:0] alu;
      logic [4:0]  dst;
      logic        exp_wb;
      logic [31:0] exp_alu;
      logic [4:0]  exp_dst;
   } vec_t;

   vec_t vecs[4];
   int   rises0;

   initial begin
      vecs[0] = '{1'b1, 32'h0000_0010, 5'd3,  1'b1, 32'h0000_0010, 5'd3};
      vecs[1] = '{1'b0, 32'hFFFF_FFFF, 5'd31, 1'b0, 32'hFFFF_FFFF, 5'd31};
      vecs[2] = '{1'b1, 32'h8000_0003, 5'd0,  1'b1, 32'h8000_0003, 5'd0};
      vecs[3] = '{1'b1, 32'h1234_5678, 5'd17, 1'b1, 32'h1234_5678, 5'd17};

      // Reset
      rst       = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      idle_inputs();
      step();
      step();
      check("reset mem_req",  32'(mem_req), 32'h0);
      check("reset WB_EN",    32'(WB_EN), 32'h0);
      check("reset ALURes",   ALURes, 32'h0);
      check("reset err",      32'(err), 32'h0);
      check("reset freeze",   32'(freeze), 32'h0);
      rst = 1'b1;
      step();

      // Pass-through table
      for (int i = 0; i < 4; i++) begin
         WB_EN_IN = vecs[i].wb;
         ALUResIn = vecs[i].alu;
         destIn   = vecs[i].dst;
         #1;
         check($sformatf("vec%0d freeze", i), 32'(freeze), 32'h0);
         step();
         check($sformatf("vec%0d WB_EN", i),    32'(WB_EN), 32'(vecs[i].exp_wb));
         check($sformatf("vec%0d ALURes", i),   ALURes, vecs[i].exp_alu);
         check($sformatf("vec%0d dest", i),     32'(dest), 32'(vecs[i].exp_dst));
         check($sformatf("vec%0d MEM_R_EN", i), 32'(MEM_R_EN), 32'h0);
         check($sformatf("vec%0d memData", i),  memData, 32'h0);
      end

      // Load with ack in cycle 3 (freeze 4 cycles)
      do_mem("load", 1'b1, 1'b0, 1'b1, 32'h0000_1007, 32'h0, 5'd7, 3, 32'hDEAD_BEEF, 1'b0);
      // Store with ack on first wait cycle
      do_mem("store", 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_55AA, 5'd0, 1, 32'h1234_5678, 1'b0);
      // Both enables set: read wins
      do_mem("rdwr", 1'b1, 1'b1, 1'b1, 32'h0000_0030, 32'h0000_0077, 5'd5, 2, 32'hCAFE_F00D, 1'b0);

      // Back-to-back loads
      rises0 = req_rises;
      do_mem("b2b_a", 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 5'd8, 2, 32'hAAAA_0001, 1'b0);
      do_mem("b2b_b", 1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 5'd9, 1, 32'hBBBB_0002, 1'b0);
      check("b2b req sequences", 32'(req_rises - rises0), 32'd2);

      // Ack on the very last wait cycle beats the timeout
      do_mem("ack_at_tmo", 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 5'd10, int'(TMO), 32'h0BAD_F00D, 1'b0);
      // Never ack: timeout
      do_mem("timeout", 1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0, 5'd11, 0, 32'h0, 1'b1);

      // Pipeline resumes; stray ack in IDLE ignored; err sticky
      idle_inputs();
      WB_EN_IN  = 1'b1;
      ALUResIn  = 32'h0000_0099;
      destIn    = 5'd4;
      mem_ack   = 1'b1;
      mem_rdata = 32'h7777_7777;
      #1;
      check("post-tmo freeze", 32'(freeze), 32'h0);
      step();
      mem_ack = 1'b0;
      check("post-tmo ALURes",  ALURes, 32'h0000_0099);
      check("post-tmo memData", memData, 32'h0);
      check("post-tmo mem_req", 32'(mem_req), 32'h0);
      check("err sticky",       32'(err), 32'h1);

      // Reset asserted mid-access
      MEM_R_EN_IN = 1'b1;
      ALUResIn    = 32'h0000_0080;
      destIn      = 5'd12;
      step();
      step();
      check("pre-rst mem_req", 32'(mem_req), 32'h1);
      rst = 1'b0;
      idle_inputs();
      #1;
      check("rst mem_req",  32'(mem_req), 32'h0);
      check("rst freeze",   32'(freeze), 32'h0);
      check("rst err",      32'(err), 32'h0);
      check("rst mem_addr", mem_addr, 32'h0);
      check("rst ALURes",   ALURes, 32'h0);
      check("rst dest",     32'(dest), 32'h0);
      step();
      rst = 1'b1;
      step();
      mem_ack   = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      step();
      mem_ack = 1'b0;
      check("late ack mem_req", 32'(mem_req), 32'h0);
      check("late ack WB_EN",   32'(WB_EN), 32'h0);
      check("late ack memData", memData, 32'h0);
      check("late ack freeze",  32'(freeze), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
